// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings, state enumeration and helpers for the multiply/divide unit.
package cpu_pkg;
  localparam logic [5:0] MULT = 6'b011000;
  localparam logic [5:0] DIV = 6'b011010;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int ITERATIONS = 32;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_WRITE, S_EXC} state_t;
  function automatic logic [31:0] mag(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one shift/subtract/restore iteration of unsigned restoring division.
module div_restore_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);
  logic [32:0] shifted, diff;
  always_comb begin
    shifted = {rem, quot[31]};
    diff = shifted - {1'b0, divisor};
    rem_next = diff[32] ? shifted[31:0] : diff[31:0];
    quot_next = {quot[30:0], ~diff[32]};
  end
endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential signed 32x32 Booth multiplier and restoring divider writing HI/LO.
module mult_div_seq
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        hi_w,
  output logic        lo_w
);
  state_t state, state_next;
  logic [4:0] cnt;
  logic last, accept;
  logic [31:0] m, rem, quot, dvs, rem_n, quot_n;
  logic q_neg, r_neg;
  // {33-bit upper with guard bit, 32-bit Q, Q-1}; the guard bit keeps -0x80000000 from overflowing
  logic [65:0] acc, acc_next;
  logic [32:0] upper, sum;
  div_restore_step u_step (
    .rem(rem),
    .quot(quot),
    .divisor(dvs),
    .rem_next(rem_n),
    .quot_next(quot_n)
  );
  always_comb begin
    upper = acc[65:33];
    sum = acc[1:0] == 2'b01 ? upper + {m[31], m} : acc[1:0] == 2'b10 ? upper - {m[31], m} : upper;
    acc_next = {sum[32], sum, acc[32:1]};
  end
  always_comb begin
    last = cnt == 5'(ITERATIONS - 1);
    accept = state == S_IDLE && start;
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = op == OP_MULT ? S_MULT : b == '0 ? S_EXC : S_DIV;
      S_MULT, S_DIV: if (last) state_next = S_WRITE;
      default: state_next = S_IDLE;
    endcase
    busy = state != S_IDLE;
    done = state == S_WRITE;
    hi_w = state == S_WRITE;
    lo_w = state == S_WRITE;
    div_zero = state == S_EXC;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_next;
      cnt <= (state == S_MULT || state == S_DIV) ? cnt + 5'd1 : '0;
      if (last && state == S_MULT) {hi, lo} <= acc_next[64:1];
      if (last && state == S_DIV) begin
        hi <= r_neg ? -rem_n : rem_n;
        lo <= q_neg ? -quot_n : quot_n;
      end
    end
  always_ff @(posedge clk)
    if (accept) begin
      m <= a;
      acc <= {33'd0, b, 1'b0};
      rem <= '0;
      quot <= mag(a);
      dvs <= mag(b);
      q_neg <= a[31] ^ b[31];
      r_neg <= a[31];
    end else begin
      if (state == S_MULT) acc <= acc_next;
      if (state == S_DIV) begin
        rem <= rem_n;
        quot <= quot_n;
      end
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: random and directed checks of mult_div_seq against a cycle-count arithmetic model.
module tb_mult_div_seq;
  logic clk = 0, reset = 1, start = 0, op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, done, div_zero, hi_w, lo_w;
  logic [31:0] hi, lo;
  int n_cmp = 0, n_bad = 0;
  int left = 0;
  bit exc = 0, armed = 0;
  logic [31:0] ph = 0, pl = 0, eh = 0, el = 0;
  logic [63:0] t;
  longint sa, sb;
  logic [31:0] specials [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h10000};

  mult_div_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo), .hi_w(hi_w), .lo_w(lo_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: an accepted op occupies 33 cycles (1 for divide by zero); results appear in the last one.
  always @(posedge clk) begin
    if (reset) begin
      left = 0; exc = 0; eh = 0; el = 0;
    end else if (left > 0) begin
      left--;
      if (left == 1 && !exc) begin eh = ph; el = pl; end
    end else if (start) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op && b == 0) begin
        left = 1; exc = 1;
      end else begin
        left = 33; exc = 0;
        if (!op) t = 64'(sa * sb);
        else begin
          t[31:0] = 32'(sa / sb);
          t[63:32] = 32'(sa % sb);
        end
        ph = t[63:32]; pl = t[31:0];
      end
    end
    armed = 1;
  end

  always @(negedge clk)
    if (armed) begin
      check("busy", 32'(busy), 32'(left > 0));
      check("done", 32'(done), 32'(left == 1 && !exc));
      check("hi_w", 32'(hi_w), 32'(left == 1 && !exc));
      check("lo_w", 32'(lo_w), 32'(left == 1 && !exc));
      check("div_zero", 32'(div_zero), 32'(left == 1 && exc));
      check("hi", hi, eh);
      check("lo", lo, el);
    end

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input bit hold,
                        input logic [31:0] xh, input logic [31:0] xl);
    start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    check("lit_busy_first", 32'(busy), 1);
    if (!hold) start = 0;
    a = $urandom; b = $urandom;
    repeat (32) @(posedge clk);
    #1;
    check("lit_done", 32'(done), 1);
    check("lit_hi_w", 32'(hi_w), 1);
    check("lit_lo_w", 32'(lo_w), 1);
    check("lit_busy_last", 32'(busy), 1);
    check("lit_hi", hi, xh);
    check("lit_lo", lo, xl);
    @(posedge clk); #1;
    check("lit_idle_busy", 32'(busy), 0);
    check("lit_idle_done", 32'(done), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("lit_rst_hi", hi, 0);
    check("lit_rst_lo", lo, 0);
    check("lit_rst_busy", 32'(busy), 0);
    run_op(0, 32'h7, 32'hFFFFFFFD, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(1, 32'hFFFFFFF9, 32'h2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(1, 32'h56781234, 32'h10000, 0, 32'h1234, 32'h5678);
    start = 1; op = 1; a = 5; b = 0;
    @(posedge clk); #1;
    start = 0;
    check("lit_exc_dz", 32'(div_zero), 1);
    check("lit_exc_busy", 32'(busy), 1);
    check("lit_exc_done", 32'(done), 0);
    check("lit_exc_hw", 32'(hi_w), 0);
    check("lit_exc_hi", hi, 32'h1234);
    check("lit_exc_lo", lo, 32'h5678);
    @(posedge clk); #1;
    check("lit_exc_dz_end", 32'(div_zero), 0);
    check("lit_exc_busy_end", 32'(busy), 0);
    run_op(1, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000);
    start = 1; op = 0; a = 32'h12345; b = 32'h6789;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("lit_abort_busy", 32'(busy), 0);
    check("lit_abort_hi", hi, 0);
    run_op(0, 32'h10000, 32'h10000, 0, 32'h1, 32'h0);
    run_op(0, 32'h3, 32'h5, 1, 32'h0, 32'hF);
    check("lit_b2b_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("lit_b2b_accept", 32'(busy), 1);
    start = 0;
    repeat (34) @(posedge clk);
    #1;
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(299) == 0;
      start = $urandom_range(1);
      op = $urandom_range(1);
      a = $urandom_range(3) == 0 ? specials[$urandom_range(7)] : $urandom;
      b = $urandom_range(7) == 0 ? 32'h0 : $urandom_range(3) == 0 ? specials[$urandom_range(7)] : $urandom;
      @(posedge clk); #1;
    end
    reset = 0; start = 0;
    repeat (40) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
